syncronizer: RTL and testbench

- Input conditioning and route-check block for the train controller.
- Brings six asynchronous track-sensor lines (S1..S6) into the Clk domain through multi-stage flip-flop synchronizers.
- Evaluates a Selector-chosen condition on the synchronized sensors and drives a single registered go/occupied flag Y, gated by Enable.
- Sits between the raw sensor pins and the controller FSM.

---
 rtl/syncronizer.sv | 110 +++++++++++
 tb/tb_syncronizer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/syncronizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : syncronizer
//  Description : Input conditioning and route check for the train controller.
//                Six asynchronous track-sensor lines are brought into the Clk
//                domain through SYNC_STAGES-deep flop chains. A condition
//                chosen by Selector is evaluated on the synchronized values
//                and registered into Y, gated by Enable.
//
//  Parameters  : SYNC_STAGES - flops per sensor synchronizer (legal 2..4)
//
//  Ports       : Clk       in   system clock, rising edge
//                Rst_n     in   asynchronous active-low reset
//                S1..S6    in   track sensors, asynchronous to Clk
//                Selector  in   [4:3] mode, [2:0] index (synchronous)
//                Enable    in   output enable (synchronous)
//                Y         out  registered condition result
//
//  Revision    : 1.0  initial release
// ============================================================================
module syncronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       S4,
    input  logic       S5,
    input  logic       S6,
    input  logic [4:0] Selector,
    input  logic       Enable,
    output logic       Y
);

    localparam logic [1:0] c_MODE_SINGLE = 2'b00;
    localparam logic [1:0] c_MODE_PAIR   = 2'b01;
    localparam logic [1:0] c_MODE_ANY    = 2'b10;
    localparam logic [1:0] c_MODE_ALL    = 2'b11;
    localparam logic [2:0] c_LAST_IDX    = 3'd5;
    localparam logic [2:0] c_NUM_SENSORS = 3'd6;

    logic [5:0] w_s;      // raw sensors, bit k-1 = Sk
    logic [5:0] w_q;      // synchronized sensors, bit k-1 = Qk
    logic [7:0] w_qx;     // zero-extended so index 6/7 reads a safe 0
    logic [1:0] w_mode;
    logic [2:0] w_idx;
    logic [2:0] w_idx_next;
    logic       w_cond;
    logic       r_y;

    assign w_s = {S6, S5, S4, S3, S2, S1};

    // One independent flop chain per sensor; the last stage is the synced value.
    generate
        for (genvar k = 0; k < 6; k++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], w_s[k]};
                end
            end

            assign w_q[k] = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    assign w_qx   = {2'b00, w_q};
    assign w_mode = Selector[4:3];
    assign w_idx  = Selector[2:0];

    // Pair partner of index i; index 5 wraps around to sensor 1.
    assign w_idx_next = (w_idx == c_LAST_IDX) ? 3'd0 : (w_idx + 3'd1);

    always_comb begin
        w_cond = 1'b0;
        case (w_mode)
            c_MODE_SINGLE: begin
                if (w_idx < c_NUM_SENSORS) begin
                    w_cond = w_qx[w_idx];
                end
            end
            c_MODE_PAIR: begin
                if (w_idx < c_NUM_SENSORS) begin
                    w_cond = w_qx[w_idx] & w_qx[w_idx_next];
                end
            end
            c_MODE_ANY: w_cond = |w_q;
            c_MODE_ALL: w_cond = &w_q;
            default:    w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_y <= 1'b0;
        end else begin
            r_y <= Enable ? w_cond : 1'b0;
        end
    end

    assign Y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_syncronizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_syncronizer
//  Description : Self-checking bench for syncronizer. A reference model
//                predicts Y at every rising edge and queues the prediction;
//                a monitor pops and compares on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_syncronizer;

    localparam int SS = 2;

    logic       Clk;
    logic       Rst_n;
    logic [5:0] s;
    logic [4:0] Selector;
    logic       Enable;
    logic       Y;

    int checks = 0;
    int errors = 0;

    syncronizer #(.SYNC_STAGES(SS)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .S1       (s[0]),
        .S2       (s[1]),
        .S3       (s[2]),
        .S4       (s[3]),
        .S5       (s[4]),
        .S6       (s[5]),
        .Selector (Selector),
        .Enable   (Enable),
        .Y        (Y)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------------
    // Reference model: sensor samples seen at past edges; the value that
    // drives Y at edge n is the sample taken SS edges earlier.
    // ------------------------------------------------------------------
    logic [5:0] hist[$];
    logic       exp_q[$];

    function automatic logic cond(input logic [4:0] sel, input logic [5:0] q);
        int mode = int'(sel[4:3]);
        int i    = int'(sel[2:0]);
        logic r = 1'b0;
        if (mode == 0) begin
            if (i < 6) r = q[i];
        end else if (mode == 1) begin
            if (i < 6) r = q[i] & q[(i + 1) % 6];
        end else if (mode == 2) begin
            for (int k = 0; k < 6; k++) r = r | q[k];
        end else begin
            r = 1'b1;
            for (int k = 0; k < 6; k++) r = r & q[k];
        end
        return r;
    endfunction

    task automatic clear_hist();
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back(6'b0);
    endtask

    initial clear_hist();

    always @(negedge Rst_n) clear_hist();

    always @(posedge Clk) begin
        if (!Rst_n) begin
            clear_hist();
            exp_q.push_back(1'b0);
        end else begin
            exp_q.push_back(Enable ? cond(Selector, hist[0]) : 1'b0);
            hist.push_back(s);
            void'(hist.pop_front());
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: Y=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: Y is presented every cycle, compare against the oldest prediction.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            check("scoreboard", Y, exp_q.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 2ns after a rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic expect_y(input string name, input logic exp);
        @(negedge Clk);
        check(name, Y, exp);
    endtask

    task automatic edge_then_expect(input string name, input logic exp);
        @(posedge Clk);
        @(negedge Clk);
        check(name, Y, exp);
    endtask

    // Mid-cycle reset pulse, called just after a falling-edge check.
    task automatic reset_pulse(input string name);
        #1 Rst_n = 1'b0;
        #1 check(name, Y, 1'b0);
        #1 Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n    = 1'b0;
        s        = 6'b000011;
        Enable   = 1'b1;
        Selector = 5'd1;

        // 1: reset forces Y low immediately; S2 shows up 3 edges after release
        #1 check("reset_immediate", Y, 1'b0);
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        edge_then_expect("release_edge1", 1'b0);
        edge_then_expect("release_edge2", 1'b0);
        edge_then_expect("release_edge3", 1'b1);

        // 2: adjacent pair
        tick(); s = 6'b000011; Selector = 5'd10;
        repeat (3) tick();
        expect_y("pair_s3s4", 1'b0);
        tick(); Selector = 5'd8;
        edge_then_expect("pair_s1s2", 1'b1);

        // 3: wrap-around pair and out-of-range index
        tick(); s = 6'b100001; Selector = 5'd13;
        repeat (3) tick();
        expect_y("pair_wrap", 1'b1);
        tick(); Selector = 5'd14;
        edge_then_expect("pair_idx6", 1'b0);

        // 4: OR / AND modes
        tick(); s = 6'b001000; Selector = 5'd16;
        repeat (3) tick();
        expect_y("or_one", 1'b1);
        tick(); Selector = 5'd24;
        edge_then_expect("and_one", 1'b0);
        tick(); s = 6'b111111;
        repeat (3) tick();
        expect_y("and_all", 1'b1);

        // 5: enable gating
        tick(); s = 6'b000001; Selector = 5'd0; Enable = 1'b1;
        repeat (3) tick();
        expect_y("en_on", 1'b1);
        tick(); Enable = 1'b0;
        edge_then_expect("en_drop", 1'b0);
        tick(); Enable = 1'b1;
        edge_then_expect("en_raise", 1'b1);

        // 6: sensor latency then reset mid-run
        tick(); s = 6'b000000; Selector = 5'd2;
        repeat (3) tick();
        expect_y("lat_base", 1'b0);
        tick(); s[2] = 1'b1;
        edge_then_expect("lat_edge1", 1'b0);
        edge_then_expect("lat_edge2", 1'b0);
        edge_then_expect("lat_edge3", 1'b1);
        reset_pulse("reset_midrun");

        // Randomized traffic, checked by the scoreboard
        for (int n = 0; n < 400; n++) begin
            tick();
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 3) == 0) s[k] = ~s[k];
            end
            if ($urandom_range(0, 3) == 0) Selector = 5'($urandom_range(0, 31));
            Enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) begin
                #3;
                reset_pulse("reset_random");
            end
        end

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
